mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares the single-write/single-read-port memory model between NREQ requesters.
- Write port and read port are arbitrated independently, each with its own grant pointer and burst lock.
- Drives the memory's wr_en/wr_addr/data_in and rd_addr directly.
- Returns registered read data, tagged with a per-requester valid, one cycle after grant.

Parameters:
- NREQ, 4, number of requesters (>=2).
- WIDTH, 16, data width; matches memory WIDTH.
- SIZE, 64, memory depth in words.
- LSIZE, $clog2(SIZE), address width.
- LREQ, $clog2(NREQ), requester index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- wr_req  in  NREQ  per-requester write request (beat offered).
- wr_last  in  NREQ  final beat of the requester's write burst.
- wr_addr  in  NREQ x LSIZE  per-requester write address.
- wr_data  in  NREQ x WIDTH  per-requester write data.
- wr_gnt  out  NREQ  one-hot (or zero); beat accepted this cycle.
- rd_req  in  NREQ  per-requester read request.
- rd_last  in  NREQ  final beat of the requester's read burst.
- rd_addr  in  NREQ x LSIZE  per-requester read address.
- rd_gnt  out  NREQ  one-hot (or zero); read beat accepted this cycle.
- rd_valid  out  NREQ  one-hot; rd_data belongs to this requester.
- rd_data  out  WIDTH  registered read data, shared bus.
- mem_wr_en  out  1  to memory wr_en.
- mem_wr_addr  out  LSIZE  to memory wr_addr.
- mem_data_in  out  WIDTH  to memory data_in.
- mem_rd_addr  out  LSIZE  to memory rd_addr.
- mem_data_out  in  WIDTH  from memory data_out (combinational read).

Behaviour:
- Reset (rst==0 at posedge) clears:
  - both FSMs to IDLE; both pointers and owners to 0;
  - rd_valid=0, rd_data=0.
- Reset is synchronous and overrides everything. A burst in progress is abandoned, and no write is issued in the reset cycle (mem_wr_en forced 0 while rst==0).
- Grants are combinational from current state and requests. A beat transfers in the cycle where req[i] && gnt[i]; gnt[i] is never asserted without req[i].
- Per-port FSM, identical for write and read:
  - IDLE: grant the first asserted req scanning ptr, ptr+1, ... mod NREQ.
    - Granted beat with last=1: stay IDLE, ptr <= granted+1 mod NREQ.
    - Granted beat with last=0: go LOCKED, owner <= granted.
  - LOCKED: grant only the owner, and only when req[owner]=1. Other requesters wait.
    - req[owner]=0: no grant, stay LOCKED (owner may stall mid-burst).
    - Granted beat with last=1: go IDLE, ptr <= owner+1 mod NREQ.
- Write path:
  - mem_wr_en = |wr_gnt; mem_wr_addr/mem_data_in muxed from the granted requester, else 0.
  - The write lands at the posedge ending the grant cycle.
- Read path:
  - mem_rd_addr muxed from the granted requester, else 0.
  - Registered at posedge: rd_data <= mem_data_out, rd_valid <= rd_gnt. Latency is exactly 1 cycle.
  - With no grant, rd_valid=0 and rd_data holds its last value.
- Same-cycle read and write to the same address returns the OLD data; the write-to-read hazard is not bypassed.
- Write and read ports are fully independent: a requester may hold write and read grants simultaneously.
- Pointer wrap: NREQ-1 +1 -> 0. When NREQ is not a power of two, the modulo is explicit.
- No starvation: while IDLE, every requester waits at most NREQ-1 bursts.

Decomposition:
- defines_pkg gains:
  - arb_state_t enum {ARB_IDLE, ARB_LOCKED};
  - constant ARB_NREQ_DEFAULT=4.
- Sub-module rr_port_arb (parameters NREQ, LREQ):
  - inputs clk, rst, req[NREQ], last[NREQ];
  - output gnt[NREQ] and granted index;
  - holds FSM, ptr and owner.
- Instantiated twice (write, read). The top holds the data/address muxes and the read-return register.

Test Plan:
- Reset: drive rst=0 for 2 cycles with all req=1 -> all gnt=0, mem_wr_en=0, rd_valid=0, rd_data=0; first cycle after release grants requester 0 on both ports.
- Round robin: all four wr_req=1 with wr_last=1 for 8 cycles -> wr_gnt sequence 0,1,2,3,0,1,2,3; memory at wr_addr[i]=i holds wr_data[i]=16'hA0+i.
- Burst lock: requester 2 writes 3 beats (last on beat 3) with requesters 0 and 1 also requesting -> wr_gnt[2] for 3 consecutive transfers; next grant goes to 3 if requesting, else 0.
- Owner stall: requester 1 read burst drops rd_req for 2 cycles mid-burst while 0 requests -> rd_gnt=0 both cycles; burst resumes with requester 1; rd_valid[1] follows each rd_gnt[1] by exactly 1 cycle.
- Same-address collision: mem[5]=16'h1111; requester 0 writes 16'h2222 to 5 while requester 1 reads 5 in the same cycle -> rd_data=16'h1111 next cycle; a repeat read returns 16'h2222.
- Reset mid-burst: assert rst during a locked 4-beat write after beat 2 -> beats 3-4 are not written; FSM IDLE, ptr 0, memory cleared by the memory's own reset.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  localparam int ARB_NREQ_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_port_arb.sv
// Round-robin grant engine with burst lock; one instance per memory port.
module rr_port_arb
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ = ARB_NREQ_DEFAULT,
  parameter int LREQ = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic [LREQ-1:0] idx
);

  arb_state_t      r_state;
  logic [LREQ-1:0] r_ptr;
  logic [LREQ-1:0] r_owner;

  logic            w_found;
  logic [LREQ-1:0] w_idx;
  logic [LREQ-1:0] w_cand;
  logic [LREQ-1:0] w_next;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    gnt     = '0;
    if (rst) begin
      if (r_state == ARB_LOCKED) begin
        if (req[r_owner]) begin
          w_found = 1'b1;
          w_idx   = r_owner;
        end
      end else begin
        // Explicit modulo keeps the scan correct for non-power-of-two NREQ.
        for (int unsigned k = 0; k < NREQ; k++) begin
          w_cand = LREQ'((32'(r_ptr) + k) % NREQ);
          if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
          end
        end
      end
    end
    if (w_found) gnt[w_idx] = 1'b1;
  end

  assign idx    = w_idx;
  assign w_next = (w_idx == LREQ'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else if (w_found) begin
      if (last[w_idx]) begin
        r_state <= ARB_IDLE;
        r_ptr   <= w_next;
      end else begin
        r_state <= ARB_LOCKED;
        r_owner <= w_idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one write port and one read port of a memory among NREQ requesters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ  = ARB_NREQ_DEFAULT,
  parameter int WIDTH = 16,
  parameter int SIZE  = 64,
  parameter int LSIZE = $clog2(SIZE),
  parameter int LREQ  = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             wr_req,
  input  logic [NREQ-1:0]             wr_last,
  input  logic [NREQ-1:0][LSIZE-1:0]  wr_addr,
  input  logic [NREQ-1:0][WIDTH-1:0]  wr_data,
  output logic [NREQ-1:0]             wr_gnt,
  input  logic [NREQ-1:0]             rd_req,
  input  logic [NREQ-1:0]             rd_last,
  input  logic [NREQ-1:0][LSIZE-1:0]  rd_addr,
  output logic [NREQ-1:0]             rd_gnt,
  output logic [NREQ-1:0]             rd_valid,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        mem_wr_en,
  output logic [LSIZE-1:0]            mem_wr_addr,
  output logic [WIDTH-1:0]            mem_data_in,
  output logic [LSIZE-1:0]            mem_rd_addr,
  input  logic [WIDTH-1:0]            mem_data_out
);

  logic [LREQ-1:0] w_wr_idx;
  logic [LREQ-1:0] w_rd_idx;
  logic            w_wr_any;
  logic            w_rd_any;

  rr_port_arb #(.NREQ(NREQ), .LREQ(LREQ)) u_wr_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (wr_req),
    .last (wr_last),
    .gnt  (wr_gnt),
    .idx  (w_wr_idx)
  );

  rr_port_arb #(.NREQ(NREQ), .LREQ(LREQ)) u_rd_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (rd_req),
    .last (rd_last),
    .gnt  (rd_gnt),
    .idx  (w_rd_idx)
  );

  assign w_wr_any    = |wr_gnt;
  assign w_rd_any    = |rd_gnt;
  assign mem_wr_en   = w_wr_any;
  assign mem_wr_addr = w_wr_any ? wr_addr[w_wr_idx] : '0;
  assign mem_data_in = w_wr_any ? wr_data[w_wr_idx] : '0;
  assign mem_rd_addr = w_rd_any ? rd_addr[w_rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_gnt;
      if (w_rd_any) rd_data <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port-pair memory.
module tb_mem_port_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 16;
  localparam int SIZE = 64;
  localparam int LSIZE = 6;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NREQ-1:0]            wr_req, wr_last, rd_req, rd_last;
  logic [NREQ-1:0][LSIZE-1:0] wr_addr, rd_addr;
  logic [NREQ-1:0][WIDTH-1:0] wr_data;
  logic [NREQ-1:0]            wr_gnt, rd_gnt, rd_valid;
  logic [WIDTH-1:0]           rd_data, mem_data_in, mem_data_out;
  logic                       mem_wr_en;
  logic [LSIZE-1:0]           mem_wr_addr, mem_rd_addr;
  logic [WIDTH-1:0]           mem [SIZE];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_last(wr_last), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_last(rd_last), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_data_in(mem_data_in),
    .mem_rd_addr(mem_rd_addr), .mem_data_out(mem_data_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= '0;
    end else if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_data_in;
    end
  end
  assign mem_data_out = mem[mem_rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    wr_req = '1; wr_last = '1; rd_req = '1; rd_last = '1;
    for (int i = 0; i < NREQ; i++) begin
      wr_addr[i] = LSIZE'(i);
      wr_data[i] = WIDTH'(16'hA0 + i);
      rd_addr[i] = '0;
    end

    // Reset held two cycles with every request up.
    #3;
    chk("rst_wr_gnt0", wr_gnt, 0);
    chk("rst_rd_gnt0", rd_gnt, 0);
    chk("rst_wr_en0", mem_wr_en, 0);
    tick();
    #3;
    chk("rst_wr_gnt1", wr_gnt, 0);
    chk("rst_rd_gnt1", rd_gnt, 0);
    chk("rst_wr_en1", mem_wr_en, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    tick();

    // Round robin, single-beat bursts on both ports.
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #3;
      chk("rr_wr_gnt", wr_gnt, 32'(1 << (k % 4)));
      chk("rr_rd_gnt", rd_gnt, 32'(1 << (k % 4)));
      chk("rr_wr_en", mem_wr_en, 1);
      chk("rr_rd_valid", rd_valid, (k == 0) ? 0 : 32'(1 << ((k - 1) % 4)));
      if (k == 1) chk("rr_rd_data_old", rd_data, 0);
      if (k == 5) chk("rr_rd_data", rd_data, 16'hA0);
      tick();
    end
    wr_req = '0; rd_req = '0;
    #3;
    chk("rr_idle_gnt", wr_gnt, 0);
    chk("rr_last_valid", rd_valid, 4'b1000);
    tick();
    for (int i = 0; i < NREQ; i++) chk("rr_mem", mem[i], 16'hA0 + i);

    // Move write pointer to 2 via a single beat from requester 1.
    wr_req = 4'b0010; wr_addr[1] = 6'd30; wr_data[1] = 16'h0055;
    #3; chk("pre_burst_gnt", wr_gnt, 4'b0010); tick();

    // Requester 2 three-beat burst while 0 and 1 also request.
    wr_req = 4'b0111; wr_last = 4'b1011;
    wr_addr[2] = 6'd10; wr_data[2] = 16'h00C0;
    #3; chk("burst_b1", wr_gnt, 4'b0100); tick();
    wr_addr[2] = 6'd11; wr_data[2] = 16'h00C1;
    #3; chk("burst_b2", wr_gnt, 4'b0100); tick();
    wr_addr[2] = 6'd12; wr_data[2] = 16'h00C2; wr_last = 4'b1111;
    #3; chk("burst_b3", wr_gnt, 4'b0100); tick();
    #3; chk("burst_next", wr_gnt, 4'b0001); tick();
    wr_req = '0;
    chk("burst_mem10", mem[10], 16'h00C0);
    chk("burst_mem11", mem[11], 16'h00C1);
    chk("burst_mem12", mem[12], 16'h00C2);

    // Read burst by requester 1 with owner stall.
    rd_req = 4'b0010; rd_last = 4'b0000; rd_addr[1] = 6'd2; rd_addr[0] = 6'd1;
    #3; chk("stall_b1", rd_gnt, 4'b0010); tick();
    rd_req = 4'b0001; rd_last = 4'b0001;
    #3;
    chk("stall_gnt1", rd_gnt, 0);
    chk("stall_valid1", rd_valid, 4'b0010);
    chk("stall_data1", rd_data, 16'hA2);
    tick();
    #3;
    chk("stall_gnt2", rd_gnt, 0);
    chk("stall_valid2", rd_valid, 0);
    tick();
    rd_req = 4'b0011; rd_last = 4'b0011; rd_addr[1] = 6'd3;
    #3;
    chk("stall_b2", rd_gnt, 4'b0010);
    chk("stall_valid3", rd_valid, 0);
    tick();
    #3;
    chk("stall_after", rd_gnt, 4'b0001);
    chk("stall_valid4", rd_valid, 4'b0010);
    chk("stall_data4", rd_data, 16'hA3);
    tick();
    rd_req = '0;
    #3;
    chk("stall_valid5", rd_valid, 4'b0001);
    chk("stall_data5", rd_data, 16'hA1);
    tick();

    // Same-address write/read collision returns the old word.
    wr_req = 4'b0001; wr_addr[0] = 6'd5; wr_data[0] = 16'h1111;
    #3; chk("col_w1", wr_gnt, 4'b0001); tick();
    wr_data[0] = 16'h2222; rd_req = 4'b0010; rd_addr[1] = 6'd5;
    #3;
    chk("col_w2", wr_gnt, 4'b0001);
    chk("col_r1", rd_gnt, 4'b0010);
    tick();
    wr_req = '0;
    #3;
    chk("col_r2", rd_gnt, 4'b0010);
    chk("col_valid1", rd_valid, 4'b0010);
    chk("col_old", rd_data, 16'h1111);
    tick();
    rd_req = '0;
    #3;
    chk("col_valid2", rd_valid, 4'b0010);
    chk("col_new", rd_data, 16'h2222);
    tick();

    // Reset during a locked four-beat write by requester 3.
    wr_req = 4'b1000; wr_last = 4'b0000; wr_addr[3] = 6'd20; wr_data[3] = 16'h00B0;
    #3; chk("rstb_b1", wr_gnt, 4'b1000); tick();
    wr_addr[3] = 6'd21; wr_data[3] = 16'h00B1;
    #3; chk("rstb_b2", wr_gnt, 4'b1000); tick();
    chk("rstb_mem20", mem[20], 16'h00B0);
    chk("rstb_mem21", mem[21], 16'h00B1);
    rst = 1'b0; wr_addr[3] = 6'd22; wr_data[3] = 16'h00B2;
    #3;
    chk("rstb_gnt", wr_gnt, 0);
    chk("rstb_wr_en", mem_wr_en, 0);
    tick();
    rst = 1'b1; wr_req = '0;
    for (int a = 20; a < 24; a++) chk("rstb_mem_clr", mem[a], 0);
    chk("rstb_valid", rd_valid, 0);
    wr_req = 4'b1111; wr_last = 4'b1111;
    #3; chk("rstb_ptr0", wr_gnt, 4'b0001); tick();
    wr_req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
